neuron_mac_p: RTL and testbench

Parametrised successor to the single-lane fixed neuron. It accumulates LANES input/weight products per beat from per-lane weight banks and adds a loaded bias. It applies a runtime-selectable activation (identity / ReLU / hard-sigmoid) and returns the result over a valid/ready output handshake. Instantiated per neuron inside a layer; weights and bias are loaded through the shared config bus keyed by layer and neuron number.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/neuron_weight_bank.sv | 23 ++
 rtl/neuron_mac_p.sv | 215 +++++++++++++++++++++
 tb/tb_neuron_mac_p.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared encodings, FSM state type and width/constant helpers for the
// parametrised MAC neuron.
package neuron_pkg;

  localparam logic [1:0] ACT_IDENT = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_HSIG  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_BIAS,
    ST_ACT,
    ST_DONE
  } state_e;

  // Headroom for NUM_WEIGHT full-scale products.
  function automatic int acc_width(input int data_w, input int num_weight);
    return 2 * data_w + $clog2(num_weight);
  endfunction

  function automatic int hsig_half(input int frac_w);
    return 1 << (frac_w - 1);
  endfunction

  function automatic int hsig_one(input int frac_w);
    return 1 << frac_w;
  endfunction

endpackage

// File: rtl/neuron_weight_bank.sv
// One lane of weight storage: simple dual-port RAM, synchronous read,
// contents deliberately not reset.
module neuron_weight_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/neuron_mac_p.sv
// Multi-lane MAC neuron: per-lane weight banks, bias, selectable activation,
// valid/ready result. Define NEURON_SAT_EN for saturating accumulate/convert.
module neuron_mac_p
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NUM_WEIGHT = 128,
  parameter int LANES      = 2,
  parameter int CFG_W      = 8,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CFG_W-1:0]        cfg_layer,
  input  logic [CFG_W-1:0]        cfg_neuron,
  input  logic                    weight_valid,
  input  logic [DATA_W-1:0]       weight_value,
  input  logic                    bias_valid,
  input  logic [DATA_W-1:0]       bias_value,
  input  logic [1:0]              act_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    busy
);

  localparam int D     = NUM_WEIGHT / LANES;
  localparam int ACC_W = acc_width(DATA_W, NUM_WEIGHT);
  localparam int PW    = 2 * DATA_W;
  localparam int AW    = (D > 1) ? $clog2(D) : 1;
  localparam int IW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam logic signed [DATA_W:0] HSIG_HALF = (DATA_W+1)'(hsig_half(FRAC_W));
  localparam logic signed [DATA_W:0] HSIG_ONE  = (DATA_W+1)'(hsig_one(FRAC_W));

  state_e                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             widx_q, widx_d;
  logic [DATA_W-1:0]         bias_q;
  logic [1:0]                act_q, act_d;
  logic                      s1_v_q, s2_v_q, s3_v_q;
  logic [LANES*DATA_W-1:0]   x_q;
  logic signed [PW-1:0]      prod_q [LANES];
  logic signed [PW-1:0]      prod_d [LANES];
  logic signed [ACC_W-1:0]   sum_q, sum_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         out_q, out_d;
  logic                      ov_q, ov_d;
  logic [DATA_W-1:0]         w_rd [LANES];
  logic                      load_sel, wr_en, in_fire;
  int                        wr_lane;
  logic [AW-1:0]             wr_addr;
  logic signed [ACC_W-1:0]   bias_ext, x_full;
  logic signed [DATA_W-1:0]  x_conv;
  logic signed [DATA_W:0]    h;
  logic [DATA_W-1:0]         y;

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef NEURON_SAT_EN
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s[ACC_W-1:0];
  endfunction

  assign load_sel = (state_q == ST_IDLE) && (cfg_layer == CFG_W'(LAYER_NO)) &&
                    (cfg_neuron == CFG_W'(NEURON_NO));
  assign wr_en    = load_sel && weight_valid;
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign in_fire  = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  assign out_valid = ov_q;
  assign out_data  = out_q;

  // Weight i lands in lane i%LANES at row i/LANES.
  always_comb begin
    wr_lane = int'(widx_q) % LANES;
    wr_addr = AW'(int'(widx_q) / LANES);
    widx_d  = (widx_q == IW'(NUM_WEIGHT - 1)) ? '0 : widx_q + IW'(1);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    neuron_weight_bank #(.DATA_W(DATA_W), .DEPTH(D), .AW(AW)) u_bank (
      .clk     (clk),
      .we_i    (wr_en && (wr_lane == k)),
      .waddr_i (wr_addr),
      .wdata_i (weight_value),
      .raddr_i (cnt_q),
      .rdata_o (w_rd[k])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = $signed(x_q[k*DATA_W +: DATA_W]) * $signed(w_rd[k]);
      sum_d     = sum_d + ACC_W'(prod_q[k]);
    end
  end

  assign bias_ext = ACC_W'($signed(bias_q)) <<< FRAC_W;
  assign x_full   = acc_q >>> FRAC_W;

  always_comb begin
`ifdef NEURON_SAT_EN
    if (x_full > $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}}))
      x_conv = {1'b0, {(DATA_W-1){1'b1}}};
    else if (x_full < $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}}))
      x_conv = {1'b1, {(DATA_W-1){1'b0}}};
    else
      x_conv = x_full[DATA_W-1:0];
`else
    x_conv = x_full[DATA_W-1:0];
`endif
    h = {x_conv[DATA_W-1], x_conv >>> 2} + HSIG_HALF;
    y = x_conv;
    case (act_q)
      ACT_IDENT: y = x_conv;
      ACT_RELU:  y = x_conv[DATA_W-1] ? '0 : x_conv;
      ACT_HSIG: begin
        if (h < 0)             y = '0;
        else if (h > HSIG_ONE) y = HSIG_ONE[DATA_W-1:0];
        else                   y = h[DATA_W-1:0];
      end
      default:   y = x_conv;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (in_fire) begin
          if (state_q == ST_IDLE) begin
            act_d = act_mode;
            acc_d = '0;
          end
          if (cnt_q == AW'(D - 1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = ST_ACC;
          end
        end
      end
      // Only the final beat is left in flight once s3 is the sole valid stage.
      ST_DRAIN: if (s3_v_q && !s2_v_q && !s1_v_q) state_d = ST_BIAS;
      ST_BIAS: begin
        acc_d   = acc_add(acc_q, bias_ext);
        state_d = ST_ACT;
      end
      ST_ACT: begin
        out_d   = y;
        ov_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (s3_v_q) acc_d = acc_add(acc_q, sum_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bias_q  <= '0;
      act_q   <= ACT_IDENT;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s3_v_q  <= 1'b0;
      x_q     <= '0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      s1_v_q  <= in_fire;
      s2_v_q  <= s1_v_q;
      s3_v_q  <= s2_v_q;
      x_q     <= in_data;
      for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      if (wr_en) widx_q <= widx_d;
      if (load_sel && bias_valid) bias_q <= bias_value;
    end
  end

endmodule

// File: tb/tb_neuron_mac_p.sv
// Directed bench for neuron_mac_p with a behavioural reference neuron and a
// per-cycle compare of out_valid/out_data/in_ready/busy.
module tb_neuron_mac_p;

  localparam int DATA_W     = 16;
  localparam int FRAC_W     = 8;
  localparam int NUM_WEIGHT = 4;
  localparam int LANES      = 2;
  localparam int CFG_W      = 8;
  localparam int D          = NUM_WEIGHT / LANES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CFG_W-1:0] cfg_layer = 8'd1, cfg_neuron = 8'd0;
  logic weight_valid = 1'b0, bias_valid = 1'b0;
  logic [DATA_W-1:0] weight_value = '0, bias_value = '0;
  logic [1:0] act_mode = 2'd0;
  logic in_valid = 1'b0, in_ready;
  logic [LANES*DATA_W-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic busy;

  neuron_mac_p #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .NUM_WEIGHT(NUM_WEIGHT), .LANES(LANES),
    .CFG_W(CFG_W), .LAYER_NO(1), .NEURON_NO(0)
  ) dut (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference neuron state: weight i is simply entry i of a flat array.
  logic [DATA_W-1:0] m_w [NUM_WEIGHT];
  logic [DATA_W-1:0] m_in [NUM_WEIGHT];
  logic [DATA_W-1:0] m_bias = '0;
  logic [DATA_W-1:0] m_res = '0;
  logic [1:0] m_act = 2'd0;
  int m_widx = 0, m_beat = 0;
  bit m_busy = 0, m_inrdy = 1, m_pend = 0;
  longint cyc = 0, m_due = 0;

  function automatic logic [DATA_W-1:0] neuron_ref();
    longint acc, x, hs;
    logic [63:0] xb;
    acc = 0;
    for (int i = 0; i < NUM_WEIGHT; i++)
      acc += longint'($signed(m_w[i])) * longint'($signed(m_in[i]));
    acc += longint'($signed(m_bias)) * (longint'(1) << FRAC_W);
    x = acc >>> FRAC_W;
`ifdef NEURON_SAT_EN
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
`else
    xb = x;
    x = longint'($signed(xb[15:0]));
`endif
    case (m_act)
      2'd1: if (x < 0) x = 0;
      2'd2: begin
        hs = (x >>> 2) + (longint'(1) << (FRAC_W - 1));
        if (hs < 0) hs = 0;
        if (hs > (longint'(1) << FRAC_W)) hs = longint'(1) << FRAC_W;
        x = hs;
      end
      default: ;
    endcase
    xb = x;
    return xb[DATA_W-1:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_widx = 0; m_bias = '0; m_beat = 0;
      m_busy = 0; m_inrdy = 1; m_pend = 0;
    end else begin
      bit ov;
      ov = m_pend && (cyc >= m_due);
      if (!m_busy && cfg_layer == 8'd1 && cfg_neuron == 8'd0) begin
        if (weight_valid) begin
          m_w[m_widx] = weight_value;
          m_widx = (m_widx + 1) % NUM_WEIGHT;
        end
        if (bias_valid) m_bias = bias_value;
      end
      if (in_valid && m_inrdy) begin
        if (m_beat == 0) begin
          m_act = act_mode;
          m_busy = 1;
        end
        for (int k = 0; k < LANES; k++)
          m_in[m_beat*LANES + k] = in_data[k*DATA_W +: DATA_W];
        if (m_beat == D - 1) begin
          m_beat = 0; m_inrdy = 0; m_pend = 1;
          m_due = cyc + 6;
          m_res = neuron_ref();
        end else begin
          m_beat++;
        end
      end
      if (ov && out_ready) begin
        m_pend = 0; m_busy = 0; m_inrdy = 1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit ov;
    ov = m_pend && (cyc >= m_due);
    check("out_valid", {31'd0, out_valid}, {31'd0, ov});
    check("in_ready", {31'd0, in_ready}, {31'd0, m_inrdy});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (ov) check("out_data", {16'd0, out_data}, {16'd0, m_res});
    if (rst) check("out_data_rst", {16'd0, out_data}, 32'd0);
  end

  task automatic load_w(input logic [15:0] w);
    weight_valid = 1'b1; weight_value = w;
    @(negedge clk);
    weight_valid = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] b);
    bias_valid = 1'b1; bias_value = b;
    @(negedge clk);
    bias_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_arrive"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] act, input logic [1:0] act_after,
                     input logic [15:0] exp, input int hold);
    act_mode = act; in_valid = 1'b1; in_data = {a, a};
    @(negedge clk);
    act_mode = act_after; in_data = {b, b};
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(name);
    check(name, {16'd0, out_data}, {16'd0, exp});
    handshake(hold);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // 4 x 1.0 products plus 0.5 bias; act change after beat 0 must not matter
    repeat (3) load_w(16'h0100);
    weight_valid = 1'b1; weight_value = 16'h0100;
    bias_valid = 1'b1; bias_value = 16'h0080;
    @(negedge clk);
    weight_valid = 1'b0; bias_valid = 1'b0;
    run("t1_ident", 16'h0100, 16'h0100, 2'd0, 2'd1, 16'h0480, 5);

    repeat (4) load_w(16'hFF00);
    run("t2_relu", 16'h0100, 16'h0100, 2'd1, 2'd0, 16'h0000, 0);
    run("t2_ident", 16'h0100, 16'h0100, 2'd0, 2'd1, 16'hFC80, 0);

    repeat (4) load_w(16'h0000);
    load_b(16'h0000);
    run("t3_hsig_mid", 16'h0100, 16'h0100, 2'd2, 2'd0, 16'h0080, 0);
    load_b(16'h0800);
    run("t3_hsig_high", 16'h0100, 16'h0100, 2'd2, 2'd0, 16'h0100, 0);
    load_b(16'hF800);
    run("t3_hsig_low", 16'h0100, 16'h0100, 2'd2, 2'd0, 16'h0000, 0);

    repeat (4) load_w(16'h7F00);
    load_b(16'h0000);
`ifdef NEURON_SAT_EN
    run("t4_big", 16'h7F00, 16'h7F00, 2'd0, 2'd0, 16'h7FFF, 0);
`else
    run("t4_big", 16'h7F00, 16'h7F00, 2'd0, 2'd0, 16'h0400, 0);
`endif

    // fifth write wraps onto index 0
    repeat (4) load_w(16'h0100);
    load_w(16'h0200);
    run("t5_wrap", 16'h0100, 16'h0100, 2'd0, 2'd0, 16'h0500, 0);

    cfg_neuron = 8'd1;
    load_w(16'h0300);
    load_b(16'h0100);
    cfg_neuron = 8'd0; cfg_layer = 8'd2;
    load_w(16'h0300);
    cfg_layer = 8'd1;
    run("t6_cfg_miss", 16'h0100, 16'h0100, 2'd0, 2'd0, 16'h0500, 0);

    // loads arriving mid-inference are dropped
    act_mode = 2'd0; in_valid = 1'b1; in_data = {16'h0100, 16'h0100};
    @(negedge clk);
    in_valid = 1'b0;
    bias_valid = 1'b1; bias_value = 16'h1000;
    weight_valid = 1'b1; weight_value = 16'h0700;
    @(negedge clk);
    bias_valid = 1'b0; weight_valid = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("t6_busy_load");
    check("t6_busy_load", {16'd0, out_data}, 32'h0500);
    handshake(0);

    // abort after one beat; index and bias return to 0, weights kept
    act_mode = 2'd0; in_valid = 1'b1; in_data = {16'h0100, 16'h0100};
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t7_no_out", {31'd0, out_valid}, 32'd0);
    run("t7_after_rst", 16'h0100, 16'h0100, 2'd0, 2'd0, 16'h0500, 0);
    load_w(16'h0300);
    run("t7_idx_reset", 16'h0100, 16'h0100, 2'd0, 2'd0, 16'h0600, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
